// File: rtl/req_tracker_pkg.sv
// Shared constants and state encoding for the request tracker and its helpers.
package req_tracker_pkg;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int SVC_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SERVICE
  } state_t;

endpackage

// File: rtl/req_tracker_if.sv
// Request/grant/status bundle between the request tracker and its clients and arbiter.
interface req_tracker_if;
  import req_tracker_pkg::*;

  logic [NCH-1:0]       req_in;
  logic [NCH-1:0]       d;
  logic [NCH-1:0]       q;
  logic                 busy;
  logic [NCH-1:0]       active;
  logic [NCH-1:0]       done;
  logic [NCH*CNT_W-1:0] served_cnt;
  logic                 err;
  logic                 err_clr;

  modport master (
    output req_in, q, err_clr,
    input  d, busy, active, done, served_cnt, err
  );

  modport slave (
    input  req_in, q, err_clr,
    output d, busy, active, done, served_cnt, err
  );

endinterface

// File: rtl/req_tracker_onehot_check.sv
// Combinational one-hot detector used to validate arbiter grants.
module onehot_check
  import req_tracker_pkg::*;
#(
  parameter int W = NCH
) (
  input  logic [W-1:0] vec,
  output logic         is_onehot
);

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign is_onehot = (vec != '0) && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/req_tracker.sv
// Tracks per-channel pending requests, validates arbiter grants, and times each service.
module req_tracker
  import req_tracker_pkg::*;
#(
  parameter int SERVICE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  req_tracker_if.slave  bus
);

  localparam logic [SVC_W-1:0] SVC_LOAD = SVC_W'(SERVICE_CYCLES - 1);

  state_t             state_reg;
  logic [NCH-1:0]     pending_reg;
  logic [NCH-1:0]     pending_next;
  logic [NCH-1:0]     active_reg;
  logic [NCH-1:0]     done_reg;
  logic               busy_reg;
  logic               err_reg;
  logic [SVC_W-1:0]   svc_cnt_reg;
  logic [CNT_W-1:0]   served_reg [NCH];
  logic               grant_onehot;
  logic               grant_valid;
  logic               finish;

  onehot_check #(.W(NCH)) u_grant_chk (
    .vec       (bus.q),
    .is_onehot (grant_onehot)
  );

  assign grant_valid = grant_onehot && ((bus.q & ~pending_reg) == '0);
  assign finish      = (state_reg == SERVICE) && (svc_cnt_reg == '0);

  // A fresh request on the finishing channel re-arms it after the clear.
  assign pending_next = (pending_reg & ~(finish ? active_reg : '0)) | bus.req_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      active_reg  <= '0;
      done_reg    <= '0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
      svc_cnt_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      done_reg    <= '0;
      if (bus.err_clr) begin
        err_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (pending_reg != '0) begin
            state_reg <= ARB;
          end
        end
        ARB: begin
          if (grant_valid) begin
            active_reg  <= bus.q;
            svc_cnt_reg <= SVC_LOAD;
            busy_reg    <= 1'b1;
            state_reg   <= SERVICE;
          end else begin
            // Placed after the clear so a simultaneous new error keeps err set.
            err_reg <= 1'b1;
          end
        end
        SERVICE: begin
          if (finish) begin
            done_reg   <= active_reg;
            active_reg <= '0;
            busy_reg   <= 1'b0;
            state_reg  <= (pending_next != '0) ? ARB : IDLE;
          end else begin
            svc_cnt_reg <= svc_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_served
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          served_reg[gi] <= '0;
        end else if (finish && active_reg[gi]) begin
          served_reg[gi] <= served_reg[gi] + 1'b1;
        end
      end
      assign bus.served_cnt[gi*CNT_W +: CNT_W] = served_reg[gi];
    end
  endgenerate

  assign bus.d      = pending_reg;
  assign bus.active = active_reg;
  assign bus.done   = done_reg;
  assign bus.busy   = busy_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_req_tracker.sv
// Scoreboard bench for req_tracker paired with an MSB-wins fixed-priority arbiter model.
module tb_req_tracker;
  import req_tracker_pkg::*;

  localparam int SC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic force_en = 1'b0;
  logic [3:0] force_q = 4'b0000;
  logic [3:0] arb_q;

  int n_checks = 0;
  int n_fail = 0;
  int busy_run = 0;
  logic [3:0] exp_q [$];
  logic [7:0] exp_cnt [4];
  logic [3:0] exp_d;

  req_tracker_if bus ();

  req_tracker #(.SERVICE_CYCLES(SC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Fixed-priority arbiter: highest pending channel wins.
  always_comb begin
    arb_q = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (bus.d[i]) begin
        arb_q = 4'b0000;
        arb_q[i] = 1'b1;
      end
    end
  end

  assign bus.q = force_en ? force_q : arb_q;

  // Scoreboard: every done pulse is matched against the next expected channel.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_run = 0;
    end else begin
      if (bus.done !== 4'b0000) begin
        $display("done=%b busy_cycles=%0d served_cnt=%h", bus.done, busy_run, bus.served_cnt);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: got done=%b, expected no done pulse", bus.done);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.done !== exp_d) begin
            n_fail++;
            $display("FAIL done_order: got done=%b, expected %b", bus.done, exp_d);
          end
        end
        n_checks++;
        if (busy_run != SC) begin
          n_fail++;
          $display("FAIL busy_length: got %0d busy cycles, expected %0d", busy_run, SC);
        end
        busy_run = 0;
      end
      if (bus.busy === 1'b1) busy_run++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_done(input logic [3:0] ch);
    exp_q.push_back(ch);
    for (int i = 0; i < 4; i++) begin
      if (ch[i]) exp_cnt[i] = exp_cnt[i] + 8'd1;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && bus.busy === 1'b0 && bus.d === 4'b0000) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: got %0d services outstanding d=%b, expected idle within %0d cycles",
               exp_q.size(), bus.d, budget);
    end
  endtask

  task automatic wait_active(input logic [3:0] ch, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.active === ch && bus.busy === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_active: got active=%b, expected %b within %0d cycles", bus.active, ch, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_in = 4'b1111;
    bus.err_clr = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
    repeat (3) tick();
    n_checks++;
    if (bus.d !== 4'b0000 || bus.active !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got d=%b active=%b busy=%b done=%b, expected all zero",
               bus.d, bus.active, bus.busy, bus.done);
    end
    n_checks++;
    if (bus.served_cnt !== 32'h0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_counters: got served_cnt=%h err=%b, expected 0 and 0", bus.served_cnt, bus.err);
    end
    reset_n = 1'b1;
    bus.req_in = 4'b0000;
    tick();
    n_checks++;
    if (bus.d !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_discard: got d=%b, expected 0000", bus.d);
    end
    $display("reset: d=%b served_cnt=%h", bus.d, bus.served_cnt);
  endtask

  task automatic test_all_four();
    bus.req_in = 4'b1111;
    expect_done(4'b1000);
    expect_done(4'b0100);
    expect_done(4'b0010);
    expect_done(4'b0001);
    tick();
    bus.req_in = 4'b0000;
    n_checks++;
    if (bus.d !== 4'b1111 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_latch: got d=%b busy=%b, expected 1111 and 0", bus.d, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_latency: got busy=%b in ARB cycle, expected 0", bus.busy);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.active !== 4'b1000) begin
      n_fail++;
      $display("FAIL first_grant: got busy=%b active=%b, expected 1 and 1000", bus.busy, bus.active);
    end
    wait_idle(100);
    n_checks++;
    if (bus.served_cnt !== {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]} || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL all_four_counts: got served_cnt=%h err=%b, expected %h and 0", bus.served_cnt,
               bus.err, {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
    end
  endtask

  task automatic test_inject();
    bus.req_in = 4'b0011;
    expect_done(4'b0010);
    tick();
    bus.req_in = 4'b0000;
    wait_active(4'b0010, 20);
    bus.req_in = 4'b1100;
    expect_done(4'b1000);
    expect_done(4'b0100);
    expect_done(4'b0001);
    tick();
    bus.req_in = 4'b0000;
    wait_idle(100);
    n_checks++;
    if (bus.served_cnt !== {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]}) begin
      n_fail++;
      $display("FAIL inject_counts: got served_cnt=%h, expected %h", bus.served_cnt,
               {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
    end
  endtask

  task automatic test_grant_error();
    force_en = 1'b1;
    force_q = 4'b0000;
    bus.req_in = 4'b0001;
    tick();
    bus.req_in = 4'b0000;
    repeat (3) tick();
    n_checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.d !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_grant: got err=%b busy=%b d=%b, expected 1, 0, 0001", bus.err, bus.busy, bus.d);
    end
    force_q = 4'b1100;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_new_err: got err=%b, expected 1", bus.err);
    end
    repeat (2) tick();
    n_checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.active !== 4'b0000 || bus.d !== 4'b0001) begin
      n_fail++;
      $display("FAIL bad_grant_hold: got err=%b busy=%b active=%b d=%b, expected 1, 0, 0000, 0001",
               bus.err, bus.busy, bus.active, bus.d);
    end
    force_en = 1'b0;
    bus.err_clr = 1'b1;
    expect_done(4'b0001);
    tick();
    bus.err_clr = 1'b0;
    n_checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.active !== 4'b0001) begin
      n_fail++;
      $display("FAIL err_clear_grant: got err=%b busy=%b active=%b, expected 0, 1, 0001",
               bus.err, bus.busy, bus.active);
    end
    wait_idle(50);
    $display("grant_error: served_cnt=%h", bus.served_cnt);
  endtask

  task automatic test_rerequest();
    bus.req_in = 4'b0100;
    expect_done(4'b0100);
    expect_done(4'b0100);
    tick();
    bus.req_in = 4'b0000;
    wait_active(4'b0100, 20);
    repeat (SC - 1) tick();
    bus.req_in = 4'b0100;
    tick();
    bus.req_in = 4'b0000;
    n_checks++;
    if (bus.done !== 4'b0100 || bus.d !== 4'b0100 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rereq_complete: got done=%b d=%b busy=%b, expected 0100, 0100, 0",
               bus.done, bus.d, bus.busy);
    end
    wait_idle(50);
    n_checks++;
    if (bus.served_cnt !== {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]}) begin
      n_fail++;
      $display("FAIL rereq_counts: got served_cnt=%h, expected %h", bus.served_cnt,
               {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
    end
  endtask

  task automatic test_reset_mid_service();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
    bus.req_in = 4'b1000;
    tick();
    bus.req_in = 4'b0000;
    wait_active(4'b1000, 20);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if (bus.d !== 4'b0000 || bus.active !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_state: got d=%b active=%b busy=%b done=%b, expected all zero",
               bus.d, bus.active, bus.busy, bus.done);
    end
    repeat (6) tick();
    n_checks++;
    if (bus.served_cnt !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_counts: got served_cnt=%h busy=%b, expected 0 and 0", bus.served_cnt, bus.busy);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 256; n++) begin
      bus.req_in = 4'b0001;
      expect_done(4'b0001);
      tick();
      bus.req_in = 4'b0000;
      wait_idle(50);
      if (n == 254) begin
        n_checks++;
        if (bus.served_cnt[7:0] !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_pre: got served_cnt[7:0]=%0d, expected 255", bus.served_cnt[7:0]);
        end
      end
    end
    n_checks++;
    if (bus.served_cnt !== {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]} || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_post: got served_cnt=%h err=%b, expected %h and 0", bus.served_cnt, bus.err,
               {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
    end
  endtask

  initial begin
    bus.req_in = 4'b0000;
    bus.err_clr = 1'b0;
    test_reset();
    test_all_four();
    test_inject();
    test_grant_error();
    test_rerequest();
    test_reset_mid_service();
    test_wrap();
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding services, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/req_tracker.md
REQ_TRACKER -- requirements
Module: req_tracker

Interface
REQ-001 Parameter SERVICE_CYCLES, default 2, service hold length in cycles per grant; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req_in  input  4  client request strobes; any bit high in a cycle posts a request for that channel.
REQ-005 d  output  4  registered pending-request vector presented to the priority arbiter.
REQ-006 q  input  4  arbiter grant, expected one-hot subset of d, combinational from d.
REQ-007 busy  output  1  high while in SERVICE.
REQ-008 active  output  4  registered one-hot channel under service; 0 outside SERVICE.
REQ-009 done  output  4  one-cycle pulse on the channel whose service completed.
REQ-010 served_cnt  output  32  four 8-bit per-channel completion counters, channel i at bits [8i+7:8i].
REQ-011 err  output  1  sticky protocol-error flag.
REQ-012 err_clr  input  1  clears err.

Function
REQ-013 pending[i] SHALL set on req_in[i]=1; d SHALL equal pending.
REQ-014 Repeated req_in[i] while pending[i]=1 SHALL be absorbed (no queueing depth >1 per channel).
REQ-015 FSM states: IDLE, ARB, SERVICE.
REQ-016 IDLE -> ARB when pending != 0 (evaluated on registered pending; request at cycle N visible on d at N+1, ARB entered at N+2 at earliest).
REQ-017 ARB: if q is one-hot and q & ~d == 0, latch active <= q, load service counter with SERVICE_CYCLES-1, go SERVICE.
REQ-018 ARB: q zero, multi-hot, or granting a non-pending channel SHALL set err and remain in ARB; pending unchanged.
REQ-019 SERVICE: q is ignored; counter decrements each cycle; at counter 0: clear pending for active channel, pulse done for active channel, increment that channel's served_cnt, clear active, go ARB if any other pending bit remains else IDLE.
REQ-020 Service length SHALL be exactly SERVICE_CYCLES cycles with busy high.
REQ-021 req_in for the active channel in its completion cycle SHALL win over the clear: pending stays 1, done still pulses, counter still increments.
REQ-022 served_cnt SHALL wrap 255 -> 0 without side effects.
REQ-023 err_clr and a new error in the same cycle: err SHALL remain 1.
REQ-024 All outputs other than d/active/busy/done/served_cnt/err are absent; all outputs registered.

Reset
REQ-025 reset_n=0 at a rising edge: state IDLE, pending=0, active=0, busy=0, done=0, served_cnt=0, err=0.
REQ-026 Reset asserted mid-SERVICE SHALL abort service with no done pulse and no counter increment.
REQ-027 req_in sampled during reset SHALL be discarded.

Structure
REQ-028 Package req_tracker_pkg SHALL hold NCH=4, CNT_W=8, and the state enum typedef (IDLE, ARB, SERVICE).
REQ-029 One sub-module, onehot_check: combinational, input 4-bit vector, outputs is_onehot; used for grant validation.

Verification
REQ-030 Bench pairs req_tracker with a fixed-priority (MSB-wins) arbiter model driving q from d.
REQ-031 Reset, then req_in=4'b1111 one cycle, SERVICE_CYCLES=2 -> done pulses 1000, 0100, 0010, 0001 in order, each after 2 busy cycles; served_cnt = 0x01010101; err=0.
REQ-032 req_in=4'b0011, then req_in=4'b1100 during channel-1 service -> service order 0010, 1000, 0100, 0001.
REQ-033 Force q=4'b0000, then q=4'b1100, while d=4'b0001 -> err=1, FSM stays ARB, no done; err_clr -> err=0; release q -> channel 0 served.
REQ-034 req_in[2] pulsed in channel-2 completion cycle -> done[2] pulses, pending[2] stays 1, channel 2 served again; served_cnt[23:16]=2.
REQ-035 reset_n=0 for one cycle mid-SERVICE of channel 3 -> d=0, active=0, busy=0, served_cnt unchanged-from-zero, no done.
REQ-036 256 services of channel 0 -> served_cnt[7:0] wraps to 0, other counters untouched.
